ffe_cplx: RTL and testbench

FFE_CPLX -- requirements
Module: ffe_cplx

---
 rtl/ffe_pkg.sv | 31 +++
 rtl/ffe_cplx_if.sv | 35 +++
 rtl/ffe_cplx_mult.sv | 41 ++++
 rtl/ffe_cplx.sv | 173 +++++++++++++++++
 tb/tb_ffe_cplx.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ffe_pkg.sv
// ffe_pkg: shared constants and helpers for the complex feed-forward equalizer.
//   *_D constants   : default widths used by ffe_cplx and ffe_cplx_if
//   guard_bits()    : ceil(log2(n)) growth bits for an n-term sum
//   SLICER_ONE      : slicer decision magnitude (1.0) before fractional scaling
//   ffe_state_e     : FILL/RUN sequencing states
package ffe_pkg;

    localparam int NUM_TAPS_D = 11;
    localparam int NBT_IN_D   = 8;
    localparam int NBF_IN_D   = 7;
    localparam int NBT_TAPS_D = 28;
    localparam int NBF_TAPS_D = 25;
    localparam int NBT_ERR_D  = 12;
    localparam int NBF_ERR_D  = 9;

    // Decision level is +/-1.0; shifted left by the output fraction width.
    localparam int SLICER_ONE = 1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } ffe_state_e;

    function automatic int guard_bits(input int n);
        int g;
        g = 0;
        while ((1 << g) < n) g++;
        return g;
    endfunction

endpackage

// File: rtl/ffe_cplx_if.sv
// ffe_cplx_if: sample/tap inputs and equalizer/slicer outputs of ffe_cplx.
//   i_en, i_data_I/Q, i_taps_I/Q : driven by the master (sample source + lms)
//   o_y_I/Q, o_dec_I/Q, o_err_I/Q, o_err_valid, o_run : driven by the slave (ffe_cplx)
interface ffe_cplx_if
    import ffe_pkg::*;
#(
    parameter int NUM_TAPS = NUM_TAPS_D,
    parameter int NBT_IN   = NBT_IN_D,
    parameter int NBT_TAPS = NBT_TAPS_D,
    parameter int NBT_ERR  = NBT_ERR_D
);
    logic                               i_en;
    logic signed [NBT_IN-1:0]           i_data_I;
    logic signed [NBT_IN-1:0]           i_data_Q;
    logic [NUM_TAPS*NBT_TAPS-1:0]       i_taps_I;
    logic [NUM_TAPS*NBT_TAPS-1:0]       i_taps_Q;
    logic signed [NBT_ERR-1:0]          o_y_I;
    logic signed [NBT_ERR-1:0]          o_y_Q;
    logic                               o_dec_I;
    logic                               o_dec_Q;
    logic signed [NBT_ERR-1:0]          o_err_I;
    logic signed [NBT_ERR-1:0]          o_err_Q;
    logic                               o_err_valid;
    logic                               o_run;

    modport master (
        output i_en, i_data_I, i_data_Q, i_taps_I, i_taps_Q,
        input  o_y_I, o_y_Q, o_dec_I, o_dec_Q, o_err_I, o_err_Q, o_err_valid, o_run
    );

    modport slave (
        input  i_en, i_data_I, i_data_Q, i_taps_I, i_taps_Q,
        output o_y_I, o_y_Q, o_dec_I, o_dec_Q, o_err_I, o_err_Q, o_err_valid, o_run
    );
endinterface

// File: rtl/ffe_cplx_mult.sv
// cplx_mult: registered full-precision complex multiply p = a * b.
//   clk, i_reset     : clock, async active-high reset
//   i_a_i/i_a_q      : sample (NBT_A bits signed)
//   i_b_i/i_b_q      : tap (NBT_B bits signed)
//   o_p_i/o_p_q      : product, NBT_A+NBT_B+1 bits, registered
module cplx_mult #(
    parameter int NBT_A = 8,
    parameter int NBT_B = 28
) (
    input  logic                         clk,
    input  logic                         i_reset,
    input  logic signed [NBT_A-1:0]      i_a_i,
    input  logic signed [NBT_A-1:0]      i_a_q,
    input  logic signed [NBT_B-1:0]      i_b_i,
    input  logic signed [NBT_B-1:0]      i_b_q,
    output logic signed [NBT_A+NBT_B:0]  o_p_i,
    output logic signed [NBT_A+NBT_B:0]  o_p_q
);
    localparam int NBP = NBT_A + NBT_B + 1;

    logic signed [NBP-1:0] p_i_d, p_i_q;
    logic signed [NBP-1:0] p_q_d, p_q_q;

    always_comb begin
        p_i_d = NBP'(i_a_i) * NBP'(i_b_i) - NBP'(i_a_q) * NBP'(i_b_q);
        p_q_d = NBP'(i_a_i) * NBP'(i_b_q) + NBP'(i_a_q) * NBP'(i_b_i);
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            p_i_q <= '0;
            p_q_q <= '0;
        end else begin
            p_i_q <= p_i_d;
            p_q_q <= p_q_d;
        end
    end

    assign o_p_i = p_i_q;
    assign o_p_q = p_q_q;
endmodule

// File: rtl/ffe_cplx.sv
// ffe_cplx: complex feed-forward equalizer with +/-1 slicer and error output.
//   clk, i_reset : clock, async active-high reset
//   bus (slave)  : i_en strobe, i_data_I/Q samples, flattened i_taps_I/Q;
//                  o_y_I/Q (E+2), o_dec_I/Q (E+2), o_err_I/Q + o_err_valid (E+3), o_run
// Optional macro FFE_ROUND_EN: round-half-up quantization of y (default truncates).
//
// state   | meaning
// ST_FILL | delay line not yet full; counting i_en samples
// ST_RUN  | NUM_TAPS samples taken; errors qualified until reset
module ffe_cplx
    import ffe_pkg::*;
#(
    parameter int NUM_TAPS = NUM_TAPS_D,
    parameter int NBT_IN   = NBT_IN_D,
    parameter int NBF_IN   = NBF_IN_D,
    parameter int NBT_TAPS = NBT_TAPS_D,
    parameter int NBF_TAPS = NBF_TAPS_D,
    parameter int NBT_ERR  = NBT_ERR_D,
    parameter int NBF_ERR  = NBF_ERR_D
) (
    input  logic      clk,
    input  logic      i_reset,
    ffe_cplx_if.slave bus
);
    localparam int NBP   = NBT_IN + NBT_TAPS + 1;
    localparam int NBS   = NBP + guard_bits(NUM_TAPS);
    localparam int NBR   = NBS + 1;  // one spare bit so the rounding add cannot wrap
    localparam int SHIFT = NBF_IN + NBF_TAPS - NBF_ERR;
    localparam int NBE   = NBT_ERR + 2;
    localparam int FCW   = $clog2(NUM_TAPS + 1);

    localparam logic signed [NBT_ERR-1:0] Y_MAX = {1'b0, {(NBT_ERR-1){1'b1}}};
    localparam logic signed [NBT_ERR-1:0] Y_MIN = {1'b1, {(NBT_ERR-1){1'b0}}};
    localparam logic signed [NBE-1:0]     LVL_P = NBE'(SLICER_ONE << NBF_ERR);
    localparam logic signed [NBE-1:0]     LVL_N = -LVL_P;
`ifdef FFE_ROUND_EN
    localparam logic signed [NBR-1:0]     RND_HALF = NBR'(1) <<< (SHIFT - 1);
`endif

    function automatic logic signed [NBT_ERR-1:0] quant(input logic signed [NBS-1:0] a);
        logic signed [NBR-1:0] r;
        r = NBR'(a);
`ifdef FFE_ROUND_EN
        r = r + RND_HALF;
`endif
        r = r >>> SHIFT;
        if (r > NBR'(Y_MAX)) return Y_MAX;
        if (r < NBR'(Y_MIN)) return Y_MIN;
        return r[NBT_ERR-1:0];
    endfunction

    function automatic logic signed [NBT_ERR-1:0] sat_err(input logic signed [NBE-1:0] e);
        if (e > NBE'(Y_MAX)) return Y_MAX;
        if (e < NBE'(Y_MIN)) return Y_MIN;
        return e[NBT_ERR-1:0];
    endfunction

    // ---------------- FILL/RUN sequencer ----------------
    ffe_state_e     state_q, state_d;
    logic [FCW-1:0] fill_q, fill_d;
    logic           run;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_FILL;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: if (bus.i_en && fill_q == FCW'(NUM_TAPS - 1)) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_FILL;
        endcase
    end

    always_comb begin
        run    = (state_q == ST_RUN);
        fill_d = fill_q;
        if (state_q == ST_FILL && bus.i_en) fill_d = fill_q + FCW'(1);
    end

    // ---------------- datapath ----------------
    logic signed [NBT_IN-1:0]  x_i_q [NUM_TAPS], x_i_d [NUM_TAPS];
    logic signed [NBT_IN-1:0]  x_q_q [NUM_TAPS], x_q_d [NUM_TAPS];
    logic signed [NBP-1:0]     p_i [NUM_TAPS];
    logic signed [NBP-1:0]     p_q [NUM_TAPS];
    logic signed [NBS-1:0]     acc_i_d, acc_i_q, acc_q_d, acc_q_q;
    logic signed [NBT_ERR-1:0] y_i, y_q, err_i_d, err_i_q, err_q_d, err_q_q;
    logic                      dec_i, dec_q;
    logic [3:0]                vld_d, vld_q;

    always_comb begin
        x_i_d = x_i_q;
        x_q_d = x_q_q;
        if (bus.i_en) begin
            x_i_d[0] = bus.i_data_I;
            x_q_d[0] = bus.i_data_Q;
            for (int k = 1; k < NUM_TAPS; k++) begin
                x_i_d[k] = x_i_q[k-1];
                x_q_d[k] = x_q_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_mult
        cplx_mult #(.NBT_A(NBT_IN), .NBT_B(NBT_TAPS)) u_mult (
            .clk     (clk),
            .i_reset (i_reset),
            .i_a_i   (x_i_q[k]),
            .i_a_q   (x_q_q[k]),
            .i_b_i   ($signed(bus.i_taps_I[k*NBT_TAPS +: NBT_TAPS])),
            .i_b_q   ($signed(bus.i_taps_Q[k*NBT_TAPS +: NBT_TAPS])),
            .o_p_i   (p_i[k]),
            .o_p_q   (p_q[k])
        );
    end

    always_comb begin
        acc_i_d = '0;
        acc_q_d = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc_i_d = acc_i_d + NBS'(p_i[k]);
            acc_q_d = acc_q_d + NBS'(p_q[k]);
        end
    end

    // y is a combinational view of the stage-2 sum so it clears with it on reset.
    always_comb begin
        y_i     = quant(acc_i_q);
        y_q     = quant(acc_q_q);
        dec_i   = y_i[NBT_ERR-1];
        dec_q   = y_q[NBT_ERR-1];
        err_i_d = sat_err((dec_i ? LVL_N : LVL_P) - NBE'(y_i));
        err_q_d = sat_err((dec_q ? LVL_N : LVL_P) - NBE'(y_q));
        // Run is sampled at the capture edge; the strobe then rides along with the data.
        vld_d   = {vld_q[2:0], bus.i_en & run};
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            x_i_q   <= '{default: '0};
            x_q_q   <= '{default: '0};
            acc_i_q <= '0;
            acc_q_q <= '0;
            err_i_q <= '0;
            err_q_q <= '0;
            vld_q   <= '0;
        end else begin
            x_i_q   <= x_i_d;
            x_q_q   <= x_q_d;
            acc_i_q <= acc_i_d;
            acc_q_q <= acc_q_d;
            err_i_q <= err_i_d;
            err_q_q <= err_q_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.o_y_I       = y_i;
    assign bus.o_y_Q       = y_q;
    assign bus.o_dec_I     = dec_i;
    assign bus.o_dec_Q     = dec_q;
    assign bus.o_err_I     = err_i_q;
    assign bus.o_err_Q     = err_q_q;
    assign bus.o_err_valid = vld_q[3];
    assign bus.o_run       = run;
endmodule

// File: tb/tb_ffe_cplx.sv
// tb_ffe_cplx: directed-vector bench for ffe_cplx with a dot-product reference model.
module tb_ffe_cplx;
    localparam int NT = 11;

    logic clk = 1'b0;
    logic i_reset = 1'b1;
    always #5 clk = ~clk;

    ffe_cplx_if bus ();

    logic signed [27:0] tw_i [NT];
    logic signed [27:0] tw_q [NT];

    always_comb begin
        bus.i_taps_I = '0;
        bus.i_taps_Q = '0;
        for (int k = 0; k < NT; k++) begin
            bus.i_taps_I[k*28 +: 28] = tw_i[k];
            bus.i_taps_Q[k*28 +: 28] = tw_q[k];
        end
    end

    ffe_cplx dut (
        .clk     (clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit stop_cmp = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint mx_i [NT];
    longint mx_q [NT];
    longint m_sum_i, m_sum_q, m_y_i, m_y_q, m_e_i, m_e_q;
    int     m_fill;
    bit     m_run;
    bit [3:0] m_v;

    function automatic longint sat12(input longint v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Full-precision sum has 32 fraction bits; output has 9.
    function automatic longint quant(input longint s);
        longint r;
        r = s;
`ifdef FFE_ROUND_EN
        r = r + (longint'(1) <<< 22);
`endif
        return sat12(r >>> 23);
    endfunction

    function automatic longint slicer_err(input longint y);
        return sat12(((y >= 0) ? 512 : -512) - y);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NT; k++) begin
            mx_i[k] = 0;
            mx_q[k] = 0;
        end
        m_sum_i = 0; m_sum_q = 0; m_y_i = 0; m_y_q = 0; m_e_i = 0; m_e_q = 0;
        m_fill = 0; m_run = 0; m_v = '0;
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge i_reset);
            if (i_reset) begin
                model_clear();
            end else begin
                m_e_i = slicer_err(m_y_i);
                m_e_q = slicer_err(m_y_q);
                m_y_i = quant(m_sum_i);
                m_y_q = quant(m_sum_q);
                m_sum_i = 0;
                m_sum_q = 0;
                for (int k = 0; k < NT; k++) begin
                    m_sum_i += mx_i[k] * tw_i[k] - mx_q[k] * tw_q[k];
                    m_sum_q += mx_i[k] * tw_q[k] + mx_q[k] * tw_i[k];
                end
                m_v = {m_v[2:0], bus.i_en & m_run};
                if (bus.i_en) begin
                    for (int k = NT - 1; k > 0; k--) begin
                        mx_i[k] = mx_i[k-1];
                        mx_q[k] = mx_q[k-1];
                    end
                    mx_i[0] = bus.i_data_I;
                    mx_q[0] = bus.i_data_Q;
                    if (!m_run) begin
                        m_fill++;
                        if (m_fill == NT) m_run = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        while (!stop_cmp) begin
            @(negedge clk);
            #1;
            check("y_I",       $signed(bus.o_y_I),   m_y_i);
            check("y_Q",       $signed(bus.o_y_Q),   m_y_q);
            check("dec_I",     bus.o_dec_I,          (m_y_i < 0) ? 1 : 0);
            check("dec_Q",     bus.o_dec_Q,          (m_y_q < 0) ? 1 : 0);
            check("err_I",     $signed(bus.o_err_I), m_e_i);
            check("err_Q",     $signed(bus.o_err_Q), m_e_q);
            check("err_valid", bus.o_err_valid,      m_v[3]);
            check("run",       bus.o_run,            m_run);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns at the falling edge just after capture edge E.
    task automatic pulse(input int xi, input int xq);
        @(negedge clk);
        bus.i_en     = 1'b1;
        bus.i_data_I = 8'(xi);
        bus.i_data_Q = 8'(xq);
        @(negedge clk);
        bus.i_en     = 1'b0;
    endtask

    task automatic clear_taps();
        for (int k = 0; k < NT; k++) begin
            tw_i[k] = '0;
            tw_q[k] = '0;
        end
    endtask

    int vcnt;

    initial begin
        bus.i_en = 1'b0;
        bus.i_data_I = '0;
        bus.i_data_Q = '0;
        clear_taps();
        i_reset = 1'b1;
        idle(3);
        #2;
        check("reset_y_I",  $signed(bus.o_y_I), 0);
        check("reset_err_I", $signed(bus.o_err_I), 0);
        check("reset_run",  bus.o_run, 0);
        check("reset_vld",  bus.o_err_valid, 0);
        @(negedge clk);
        i_reset = 1'b0;

        // Fill with zero taps
        for (int i = 0; i < 10; i++) pulse(0, 0);
        check("run_after_10", bus.o_run, 0);
        pulse(0, 0);
        check("run_after_11", bus.o_run, 1);
        pulse(0, 0);
        check("vld_E", bus.o_err_valid, 0);
        idle(1); check("vld_E1", bus.o_err_valid, 0);
        idle(1); check("vld_E2", bus.o_err_valid, 0);
        idle(1); check("vld_E3", bus.o_err_valid, 1);
        idle(1); check("vld_E4", bus.o_err_valid, 0);

        // Identity
        tw_i[0] = 28'sd1 <<< 25;
        pulse(64, -64);
        idle(2);
        check("id_y_I", $signed(bus.o_y_I), 256);
        check("id_y_Q", $signed(bus.o_y_Q), -256);
        check("id_dec_I", bus.o_dec_I, 0);
        check("id_dec_Q", bus.o_dec_Q, 1);
        idle(1);
        check("id_err_I", $signed(bus.o_err_I), 256);
        check("id_err_Q", $signed(bus.o_err_Q), -256);
        check("id_vld", bus.o_err_valid, 1);

        // Rotation
        tw_i[0] = '0;
        tw_q[0] = 28'sd1 <<< 25;
        pulse(64, 0);
        idle(2);
        check("rot_y_I", $signed(bus.o_y_I), 0);
        check("rot_y_Q", $signed(bus.o_y_Q), 256);
        idle(1);
        check("rot_err_I", $signed(bus.o_err_I), 512);
        check("rot_err_Q", $signed(bus.o_err_Q), 256);

        // Rounding
        tw_q[0] = '0;
        tw_i[0] = 28'sd1 <<< 16;
        pulse(64, 0);
        idle(2);
`ifdef FFE_ROUND_EN
        check("rnd_y_I", $signed(bus.o_y_I), 1);
`else
        check("rnd_y_I", $signed(bus.o_y_I), 0);
`endif

        // Saturation
        for (int k = 0; k < NT; k++) tw_i[k] = 28'sd117440512;
        for (int i = 0; i < NT; i++) pulse(-128, 0);
        idle(2);
        check("sat_y_I", $signed(bus.o_y_I), -2048);
        idle(1);
        check("sat_err_I", $signed(bus.o_err_I), 1536);

        // Mixed directed vectors, including tap changes while i_en is low
        clear_taps();
        tw_i[0] = 28'sd16777216;  tw_q[0] = -28'sd8388608;
        tw_i[1] = -28'sd4194304;  tw_q[1] = 28'sd2097152;
        tw_i[5] = 28'sd33554431;  tw_q[7] = -28'sd33554432;
        pulse(100, -27);
        pulse(-5, 127);
        pulse(-128, 90);
        idle(3);
        tw_i[2] = 28'sd50000000;
        idle(4);
        pulse(33, -1);
        pulse(0, 0);
        idle(4);

        // Reset mid-pipeline
        clear_taps();
        tw_i[0] = 28'sd1 <<< 25;
        pulse(100, -50);
        idle(1);
        #3 i_reset = 1'b1;
        #1;
        check("rst_y_I",   $signed(bus.o_y_I), 0);
        check("rst_y_Q",   $signed(bus.o_y_Q), 0);
        check("rst_dec_Q", bus.o_dec_Q, 0);
        check("rst_err_I", $signed(bus.o_err_I), 0);
        check("rst_vld",   bus.o_err_valid, 0);
        check("rst_run",   bus.o_run, 0);
        idle(2);
        @(negedge clk);
        i_reset = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (bus.o_err_valid) vcnt++;
        end
        check("no_vld_after_rst", vcnt, 0);

        // Refill after reset: first i_en counts as sample 1
        for (int i = 0; i < 10; i++) pulse(i * 7 - 30, 20 - i * 5);
        check("refill_run_10", bus.o_run, 0);
        pulse(55, -66);
        check("refill_run_11", bus.o_run, 1);
        pulse(-90, 12);
        pulse(127, -128);
        idle(5);

        stop_cmp = 1'b1;
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
